bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 102 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential double-dabble binary-to-BCD converter, one bit per clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq #(
    parameter int BIN_W = 8,
    parameter int NDIG  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd_out
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * NDIG;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BIN_W-1:0]   bin_q,   bin_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [BCD_W-1:0]   out_q,   out_d;
    logic               done_q,  done_d;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Add-3 correction so every nibble stays a valid decimal digit after the shift.
    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        assign bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ?
                                   (bcd_q[4*g +: 4] + 4'd3) : bcd_q[4*g +: 4];
    end

    assign shifted = {bcd_adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = shifted[BCD_W+BIN_W-1 : BIN_W];
                bin_d = shifted[BIN_W-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                // Last bit: publish the finished value, never the partial ones.
                if (cnt_q == CNT_W'(1)) begin
                    out_d   = shifted[BCD_W+BIN_W-1 : BIN_W];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == S_CONV);
    assign done    = done_q;
    assign bcd_out = out_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Brief    : Self-checking bench for bin_to_bcd_seq against a decimal model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

    localparam int BIN_W = 8;
    localparam int NDIG  = 3;
    localparam int BCD_W = 4 * NDIG;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [BIN_W-1:0]   bin_in = '0;
    logic               busy;
    logic               done;
    logic [BCD_W-1:0]   bcd_out;

    int total = 0;
    int bad   = 0;
    logic [BCD_W-1:0] last_res = '0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;

    // Decimal digits by repeated division, packed units-first.
    function automatic logic [BCD_W-1:0] ref_bcd(input int v);
        logic [BCD_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < NDIG; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit digits_ok(input logic [BCD_W-1:0] b);
        for (int d = 0; d < NDIG; d++)
            if (b[4*d +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after the accept edge; watches BIN_W+2 edges of the conversion.
    task automatic observe(input int v, input string tag, input int poke_at, input int poke_val);
        int busy_n, done_n, done_at, hold_err, nib_err;
        logic [BCD_W-1:0] res, exp_now;
        busy_n = 0; done_n = 0; done_at = -1; hold_err = 0; nib_err = 0; res = '0;
        for (int i = 0; i <= BIN_W + 1; i++) begin
            if (i > 0) tick;
            if (i == poke_at + 1) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = i;
                    res = bcd_out;
                end
            end
            exp_now = (done_at >= 0) ? ref_bcd(v) : last_res;
            if (bcd_out !== exp_now) hold_err++;
            if (!digits_ok(bcd_out)) nib_err++;
            if (i == poke_at) begin
                start  = 1'b1;
                bin_in = BIN_W'(poke_val);
            end else begin
                bin_in = BIN_W'($urandom);
            end
        end
        chk({tag, "_busy_cycles"}, busy_n, BIN_W);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_done_latency"}, done_at, BIN_W);
        chk({tag, "_result"}, res, ref_bcd(v));
        chk({tag, "_hold"}, hold_err, 0);
        chk({tag, "_digits"}, nib_err, 0);
        last_res = ref_bcd(v);
    endtask

    task automatic accept(input int v);
        bin_in = BIN_W'(v);
        start  = 1'b1;
        tick;
        start  = 1'b0;
    endtask

    initial begin
        int dn, v;

        // Reset for two cycles with start held high: start must be ignored.
        rst = 1'b1; start = 1'b1; bin_in = 8'd77;
        tick; tick;
        rst = 1'b0; start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd_out, 0);
        tick;
        chk("rst_start_ignored", busy, 0);

        accept(255); observe(255, "v255", -1, 0);
        accept(0);   observe(0,   "v0",   -1, 0);
        accept(99);  observe(99,  "v99",  -1, 0);
        accept(100); observe(100, "v100", -1, 0);

        // Start during conversion must be neither restarting nor queued.
        accept(137); observe(137, "ign137", 3, 42);
        tick;
        chk("ign_not_queued", busy, 0);

        // Reset mid-conversion aborts; no done afterwards.
        accept(200);
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bcd", bcd_out, 0);
        dn = 0;
        for (int i = 0; i < BIN_W + 2; i++) begin
            tick;
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_bcd_after", bcd_out, 0);
        last_res = '0;

        // Back-to-back with start held high across the done cycle.
        bin_in = 8'd9; start = 1'b1;
        tick;
        bin_in = 8'd250;
        dn = 0;
        for (int i = 1; i < BIN_W; i++) begin
            tick;
            if (done) dn++;
        end
        chk("b2b_early_done", dn, 0);
        tick;
        chk("b2b_done9", done, 1);
        chk("b2b_res9", bcd_out, ref_bcd(9));
        tick;
        start = 1'b0;
        chk("b2b_accept_busy", busy, 1);
        chk("b2b_hold9", bcd_out, ref_bcd(9));
        last_res = ref_bcd(9);
        observe(250, "b2b250", -1, 0);

        // Exhaustive sweep.
        for (int k = 0; k < (1 << BIN_W); k++) begin
            accept(k);
            observe(k, $sformatf("sweep%0d", k), -1, 0);
        end

        // Random values with random idle gaps.
        for (int k = 0; k < 40; k++) begin
            v = int'($urandom_range(0, (1 << BIN_W) - 1));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick;
            accept(v);
            observe(v, $sformatf("rand%0d", v), -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
